// File: rtl/ps2_scancode_decoder.sv
// ps2_scancode_decoder: strips set-2 E0/F0 prefixes into tagged key events queued in a FWFT FIFO.
// Define PS2_ASCII_EN to add shift tracking and a per-entry ASCII translation.
module ps2_scancode_decoder #(
  parameter int FIFO_DEPTH = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          code_valid,
  input  logic [7:0]                    code,
  input  logic                          rd_en,
  output logic [9:0]                    rd_data,
  output logic [7:0]                    ascii,
  output logic                          empty,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          overflow,
  input  logic                          ovf_clr
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
`ifdef PS2_ASCII_EN
  localparam int W = 18;
`else
  localparam int W = 10;
`endif
  localparam logic [1:0] IDLE = 2'd0, PRE_E0 = 2'd1, PRE_F0 = 2'd2, PRE_E0F0 = 2'd3;
  logic [1:0] state, state_nx;
  logic [TW-1:0] tmr;
  logic tmo, disc, pfx, push, pop, wr, drop;
  logic [W-1:0] mem [FIFO_DEPTH];
  logic [W-1:0] entry, head;
  logic [AW-1:0] wp, rp;
  assign disc = code inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF};
  assign pfx = code == 8'hE0 || code == 8'hF0;
  assign push = code_valid && !disc && !pfx;
  assign tmo = TIMEOUT_CYCLES != 0 && state != IDLE && tmr == TW'(TIMEOUT_CYCLES);
  // State bit 0 marks extended, bit 1 marks release, so the tag bits come straight from the state.
  always_comb
    state_nx = !code_valid ? (tmo ? IDLE : state) :
               (disc || !pfx) ? IDLE :
               code == 8'hE0 ? (state[1] ? PRE_E0F0 : PRE_E0) :
               (state[0] ? PRE_E0F0 : PRE_F0);
  always_ff @(posedge clk)
    if (reset || code_valid || state_nx == IDLE) tmr <= '0;
    else tmr <= tmr + 1'b1;
`ifdef PS2_ASCII_EN
  logic shift;
  logic [7:0] raw, asc;
  always_comb begin
    raw = 8'h00;
    case (code)
      8'h1C: raw = 8'h61; 8'h32: raw = 8'h62; 8'h21: raw = 8'h63; 8'h23: raw = 8'h64;
      8'h24: raw = 8'h65; 8'h2B: raw = 8'h66; 8'h34: raw = 8'h67; 8'h33: raw = 8'h68;
      8'h43: raw = 8'h69; 8'h3B: raw = 8'h6A; 8'h42: raw = 8'h6B; 8'h4B: raw = 8'h6C;
      8'h3A: raw = 8'h6D; 8'h31: raw = 8'h6E; 8'h44: raw = 8'h6F; 8'h4D: raw = 8'h70;
      8'h15: raw = 8'h71; 8'h2D: raw = 8'h72; 8'h1B: raw = 8'h73; 8'h2C: raw = 8'h74;
      8'h3C: raw = 8'h75; 8'h2A: raw = 8'h76; 8'h1D: raw = 8'h77; 8'h22: raw = 8'h78;
      8'h35: raw = 8'h79; 8'h1A: raw = 8'h7A;
      8'h45: raw = 8'h30; 8'h16: raw = 8'h31; 8'h1E: raw = 8'h32; 8'h26: raw = 8'h33;
      8'h25: raw = 8'h34; 8'h2E: raw = 8'h35; 8'h36: raw = 8'h36; 8'h3D: raw = 8'h37;
      8'h3E: raw = 8'h38; 8'h46: raw = 8'h39;
      8'h29: raw = 8'h20; 8'h5A: raw = 8'h0D; 8'h66: raw = 8'h08;
      default: raw = 8'h00;
    endcase
    asc = state != IDLE ? 8'h00 : (shift && raw inside {[8'h61:8'h7A]}) ? raw - 8'h20 : raw;
  end
  always_ff @(posedge clk)
    if (reset) shift <= 1'b0;
    else if (push && !state[0] && (code == 8'h12 || code == 8'h59)) shift <= !state[1];
  assign entry = {asc, state[0], state[1], code};
  assign ascii = empty ? 8'h00 : head[17:10];
`else
  assign entry = {state[0], state[1], code};
  assign ascii = 8'h00;
`endif
  assign head = mem[rp];
  assign rd_data = empty ? 10'h000 : head[9:0];
  assign empty = count == '0;
  assign full = count == (AW+1)'(FIFO_DEPTH);
  assign pop = rd_en && !empty;
  assign wr = push && (!full || pop);
  assign drop = push && full && !pop;
  always_ff @(posedge clk)
    if (wr) mem[wp] <= entry;
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      wp <= '0;
      rp <= '0;
      count <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_nx;
      if (wr) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      count <= count + {{AW{1'b0}}, wr} - {{AW{1'b0}}, pop};
      overflow <= drop || (overflow && !ovf_clr);
    end
endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// tb_ps2_scancode_decoder: directed and randomized checks against a queue-based event model.
module tb_ps2_scancode_decoder;
  localparam int D = 8;
  localparam int T = 20;
  localparam logic [7:0] LETTERS [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33,
    8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C,
    8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  localparam logic [7:0] DIGITS [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
    8'h3E, 8'h46};
  localparam logic [7:0] POOL [16] = '{8'hE0, 8'hF0, 8'h00, 8'hAA, 8'hFA, 8'h1C, 8'h12, 8'h59,
    8'h45, 8'h29, 8'h5A, 8'h66, 8'h75, 8'h32, 8'h16, 8'hF0};
  logic clk = 0, reset = 1, code_valid = 0, rd_en = 0, ovf_clr = 0;
  logic [7:0] code = 0, ascii;
  logic [9:0] rd_data;
  logic empty, full, overflow;
  logic [3:0] count;
  int checks = 0, errors = 0;
  logic [17:0] q [$];
  bit pe, pf, m_ovf, m_shift;

  ps2_scancode_decoder #(.FIFO_DEPTH(D), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset), .code_valid(code_valid), .code(code), .rd_en(rd_en),
    .rd_data(rd_data), .ascii(ascii), .empty(empty), .full(full), .count(count),
    .overflow(overflow), .ovf_clr(ovf_clr));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] m_ascii(input logic [7:0] c, input bit sh);
    for (int i = 0; i < 26; i++) if (c == LETTERS[i]) return (sh ? 8'h41 : 8'h61) + 8'(i);
    for (int i = 0; i < 10; i++) if (c == DIGITS[i]) return 8'h30 + 8'(i);
    return c == 8'h29 ? 8'h20 : c == 8'h5A ? 8'h0D : c == 8'h66 ? 8'h08 : 8'h00;
  endfunction

  function automatic logic [9:0] exp_rd();
    return q.size() > 0 ? q[0][9:0] : 10'h000;
  endfunction

  function automatic logic [7:0] exp_asc();
    return q.size() > 0 ? q[0][17:10] : 8'h00;
  endfunction

  task automatic model_edge(input logic cv, input logic [7:0] c, input logic rd, input logic clr);
    bit full0 = q.size() == D;
    bit popm = rd && q.size() > 0;
    bit em = 0;
    logic [7:0] a = 8'h00;
    logic [17:0] e = '0;
    if (cv) begin
      if (c inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF}) begin
        pe = 0; pf = 0;
      end else if (c == 8'hE0) pe = 1;
      else if (c == 8'hF0) pf = 1;
      else begin
        em = 1;
`ifdef PS2_ASCII_EN
        a = (!pe && !pf) ? m_ascii(c, m_shift) : 8'h00;
        if (!pe && (c == 8'h12 || c == 8'h59)) m_shift = !pf;
`endif
        e = {a, pe, pf, c};
        pe = 0; pf = 0;
      end
    end
    if (popm) void'(q.pop_front());
    if (clr) m_ovf = 0;
    if (em) begin
      if (full0 && !popm) m_ovf = 1;
      else q.push_back(e);
    end
  endtask

  task automatic cyc(input logic cv, input logic [7:0] c, input logic rd, input logic clr);
    code_valid = cv; code = c; rd_en = rd; ovf_clr = clr;
    @(posedge clk);
    if (reset) begin
      q.delete(); pe = 0; pf = 0; m_ovf = 0; m_shift = 0;
    end else model_edge(cv, c, rd, clr);
    @(negedge clk);
    code_valid = 0; rd_en = 0; ovf_clr = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    cyc(0, 0, 0, 0);
    reset = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", full); end
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", overflow); end
    checks++; if (rd_data !== 10'h000 || ascii !== 8'h00) begin errors++; $display("FAIL reset_data: got %h/%h want 000/00", rd_data, ascii); end
  endtask

  task automatic test_basic();
    cyc(1, 8'h1C, 0, 0);
    checks++; if (rd_data !== 10'h01C || count !== 4'd1 || empty !== 1'b0) begin errors++; $display("FAIL basic_push: got %h cnt %0d empty %b want 01C cnt 1 empty 0", rd_data, count, empty); end
    cyc(0, 0, 1, 0);
    checks++; if (empty !== 1'b1 || rd_data !== 10'h000) begin errors++; $display("FAIL basic_pop: got %h empty %b want 000 empty 1", rd_data, empty); end
  endtask

  task automatic test_prefix();
    cyc(1, 8'hF0, 0, 0); cyc(1, 8'h1C, 0, 0);
    checks++; if (rd_data !== 10'h11C) begin errors++; $display("FAIL prefix_break: got %h want 11C", rd_data); end
    cyc(0, 0, 1, 0);
    cyc(1, 8'hE0, 0, 0); cyc(1, 8'h75, 0, 0);
    checks++; if (rd_data !== 10'h275) begin errors++; $display("FAIL prefix_ext: got %h want 275", rd_data); end
    cyc(0, 0, 1, 0);
    cyc(1, 8'hE0, 0, 0); cyc(1, 8'hF0, 0, 0); cyc(1, 8'h75, 0, 0);
    checks++; if (rd_data !== 10'h375) begin errors++; $display("FAIL prefix_extbrk: got %h want 375", rd_data); end
    cyc(0, 0, 1, 0);
    cyc(1, 8'h1C, 0, 0);
    checks++; if (rd_data !== 10'h01C || count !== 4'd1) begin errors++; $display("FAIL prefix_idle: got %h cnt %0d want 01C cnt 1", rd_data, count); end
    cyc(0, 0, 1, 0);
    cyc(1, 8'hF0, 0, 0); cyc(1, 8'hE0, 0, 0); cyc(1, 8'hF0, 0, 0); cyc(1, 8'h14, 0, 0);
    checks++; if (rd_data !== 10'h314) begin errors++; $display("FAIL prefix_f0e0: got %h want 314", rd_data); end
    cyc(0, 0, 1, 0);
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 9; i++) cyc(1, 8'h15 + 8'(i), 0, 0);
    checks++; if (full !== 1'b1 || count !== 4'd8 || overflow !== 1'b1 || rd_data !== 10'h015) begin errors++; $display("FAIL ovf_fill: got full %b cnt %0d ovf %b head %h want 1 8 1 015", full, count, overflow, rd_data); end
    cyc(0, 0, 0, 1);
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clr: got %b want 0", overflow); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (rd_data !== 10'h015 + 10'(i)) begin errors++; $display("FAIL ovf_order%0d: got %h want %h", i, rd_data, 10'h015 + 10'(i)); end
      cyc(0, 0, 1, 0);
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL ovf_drained: got empty %b want 1", empty); end
  endtask

  task automatic test_timeout();
    cyc(1, 8'hE0, 0, 0);
    repeat (T + 1) cyc(0, 0, 0, 0);
    cyc(1, 8'h1C, 0, 0);
    checks++; if (rd_data !== 10'h01C) begin errors++; $display("FAIL timeout_expired: got %h want 01C", rd_data); end
    cyc(0, 0, 1, 0);
    cyc(1, 8'hE0, 0, 0);
    repeat (T / 2) cyc(0, 0, 0, 0);
    cyc(1, 8'h75, 0, 0);
    checks++; if (rd_data !== 10'h275) begin errors++; $display("FAIL timeout_held: got %h want 275", rd_data); end
    cyc(0, 0, 1, 0);
    cyc(1, 8'hAA, 0, 0); cyc(1, 8'hFA, 0, 0); cyc(1, 8'hFE, 0, 0);
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL discard_alone: got empty %b want 1", empty); end
    cyc(1, 8'hE0, 0, 0); cyc(1, 8'hAA, 0, 0); cyc(1, 8'h1C, 0, 0);
    checks++; if (rd_data !== 10'h01C) begin errors++; $display("FAIL discard_prefix: got %h want 01C", rd_data); end
    cyc(0, 0, 1, 0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) cyc(1, 8'h15 + 8'(i), 0, 0);
    cyc(1, 8'h2A, 1, 0);
    checks++; if (count !== 4'd8 || overflow !== 1'b0 || rd_data !== 10'h016) begin errors++; $display("FAIL full_pushpop: got cnt %0d ovf %b head %h want 8 0 016", count, overflow, rd_data); end
    repeat (7) cyc(0, 0, 1, 0);
    checks++; if (rd_data !== 10'h02A || count !== 4'd1) begin errors++; $display("FAIL full_tail: got %h cnt %0d want 02A cnt 1", rd_data, count); end
    cyc(0, 0, 1, 0);
    cyc(1, 8'hE0, 0, 0);
    do_reset();
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_mid: got empty %b want 1", empty); end
    cyc(1, 8'h75, 0, 0);
    checks++; if (rd_data !== 10'h075) begin errors++; $display("FAIL reset_mid_next: got %h want 075", rd_data); end
    cyc(0, 0, 1, 0);
  endtask

  task automatic test_ascii();
`ifdef PS2_ASCII_EN
    cyc(1, 8'h1C, 0, 0);
    checks++; if (ascii !== 8'h61) begin errors++; $display("FAIL ascii_a: got %h want 61", ascii); end
    cyc(0, 0, 1, 0);
    cyc(1, 8'h12, 0, 0); cyc(1, 8'h1C, 1, 0);
    checks++; if (ascii !== 8'h41 || rd_data !== 10'h01C) begin errors++; $display("FAIL ascii_A: got %h/%h want 41/01C", ascii, rd_data); end
    cyc(0, 0, 1, 0);
    cyc(1, 8'hF0, 0, 0); cyc(1, 8'h12, 0, 0); cyc(1, 8'h1C, 1, 0);
    checks++; if (ascii !== 8'h61) begin errors++; $display("FAIL ascii_unshift: got %h want 61", ascii); end
    cyc(0, 0, 1, 0);
    cyc(1, 8'h45, 0, 0);
    checks++; if (ascii !== 8'h30) begin errors++; $display("FAIL ascii_0: got %h want 30", ascii); end
    cyc(0, 0, 1, 0);
    cyc(1, 8'hE0, 0, 0); cyc(1, 8'h75, 0, 0);
    checks++; if (ascii !== 8'h00 || rd_data !== 10'h275) begin errors++; $display("FAIL ascii_ext: got %h/%h want 00/275", ascii, rd_data); end
    cyc(0, 0, 1, 0);
`else
    cyc(1, 8'h1C, 0, 0);
    checks++; if (ascii !== 8'h00 || rd_data !== 10'h01C) begin errors++; $display("FAIL ascii_off: got %h/%h want 00/01C", ascii, rd_data); end
    cyc(0, 0, 1, 0);
`endif
  endtask

  task automatic test_random();
    int gap = 0;
    do_reset();
    for (int n = 0; n < 500; n++) begin
      logic cv = ($urandom % 2 == 0) || gap >= 10;
      logic [7:0] c = ($urandom % 4 == 0) ? 8'($urandom) : POOL[$urandom % 16];
      gap = cv ? 0 : gap + 1;
      cyc(cv, c, $urandom % 3 == 0, $urandom % 16 == 0);
      checks++;
      if (rd_data !== exp_rd() || ascii !== exp_asc() || count !== 4'(q.size()) || empty !== (q.size() == 0) ||
          full !== (q.size() == D) || overflow !== m_ovf) begin
        errors++;
        $display("FAIL random%0d: got rd %h asc %h cnt %0d e %b f %b ovf %b want rd %h asc %h cnt %0d ovf %b",
                 n, rd_data, ascii, count, empty, full, overflow, exp_rd(), exp_asc(), q.size(), m_ovf);
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_prefix();
    test_overflow();
    test_timeout();
    test_back_to_back();
    do_reset();
    test_ascii();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
